// File: rtl/kuuga_arb_pkg.sv
// kuuga_arb_pkg
// Shared types for the instruction/data memory port arbiter.
//   arb_state_t : arbiter FSM states (IDLE, ISSUE, WAIT_RESP)
//   req_id_t    : identifies the requester that owns the memory port
package kuuga_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_RESP
    } arb_state_t;

    typedef enum logic {
        REQ_I,
        REQ_D
    } req_id_t;

    // The requester that did not win last time gets the next tie.
    function automatic req_id_t other_req(input req_id_t r);
        return (r == REQ_I) ? REQ_D : REQ_I;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_sat_counter.sv
// sat_counter
// Saturating up-counter used for the arbiter statistics.
// Ports:
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset, clears the count
//   inc   : add one this cycle (ignored once the count is all-ones)
//   count : current count value
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Stick at all-ones rather than wrapping back to zero.
    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one OBI-style memory port between the instruction-side and
// data-side refill paths. One transaction is in flight at a time; ties are
// broken round-robin.
// Ports:
//   clk, rst                        : clock and synchronous active-high reset
//   i_req/i_addr/i_we/i_be/i_wdata  : instruction-side request
//   i_gnt, i_rvalid, i_rdata        : instruction-side grant and response
//   d_req/d_addr/d_we/d_be/d_wdata  : data-side request
//   d_gnt, d_rvalid, d_rdata        : data-side grant and response
//   mem_req/addr/we/be/wdata        : downstream request
//   mem_gnt, mem_rvalid, mem_rdata  : downstream grant and response
//   i_grant_cnt, d_grant_cnt        : saturating grant counters
//   contention_cnt                  : saturating count of contended cycles
//   spurious_rvalid                 : sticky flag, response seen with none pending
module mem_port_arbiter
    import kuuga_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    i_req,
    input  logic [ADDR_WIDTH-1:0]   i_addr,
    input  logic                    i_we,
    input  logic [DATA_WIDTH/8-1:0] i_be,
    input  logic [DATA_WIDTH-1:0]   i_wdata,
    output logic                    i_gnt,
    output logic                    i_rvalid,
    output logic [DATA_WIDTH-1:0]   i_rdata,

    input  logic                    d_req,
    input  logic [ADDR_WIDTH-1:0]   d_addr,
    input  logic                    d_we,
    input  logic [DATA_WIDTH/8-1:0] d_be,
    input  logic [DATA_WIDTH-1:0]   d_wdata,
    output logic                    d_gnt,
    output logic                    d_rvalid,
    output logic [DATA_WIDTH-1:0]   d_rdata,

    output logic                    mem_req,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic                    mem_we,
    output logic [DATA_WIDTH/8-1:0] mem_be,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    input  logic                    mem_gnt,
    input  logic                    mem_rvalid,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,

    output logic [CNT_WIDTH-1:0]    i_grant_cnt,
    output logic [CNT_WIDTH-1:0]    d_grant_cnt,
    output logic [CNT_WIDTH-1:0]    contention_cnt,
    output logic                    spurious_rvalid
);

    arb_state_t state_q, state_d;
    req_id_t    sel_q, sel_d;
    req_id_t    last_sel_q, last_sel_d;
    logic       spurious_q, spurious_d;
    logic       contention_inc;

    // Next-state and output decode. While rst is high every output is held
    // at zero regardless of the state register, which only clears on the
    // next edge. mem_req depends on state alone, so there is no path from
    // mem_gnt or mem_rvalid to it.
    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        last_sel_d = last_sel_q;
        mem_req    = 1'b0;
        mem_addr   = '0;
        mem_we     = 1'b0;
        mem_be     = '0;
        mem_wdata  = '0;
        i_gnt      = 1'b0;
        d_gnt      = 1'b0;
        i_rvalid   = 1'b0;
        d_rvalid   = 1'b0;
        i_rdata    = '0;
        d_rdata    = '0;
        if (!rst) begin
            case (state_q)
                IDLE: begin
                    if (i_req && d_req) begin
                        sel_d   = other_req(last_sel_q);
                        state_d = ISSUE;
                    end else if (i_req) begin
                        sel_d   = REQ_I;
                        state_d = ISSUE;
                    end else if (d_req) begin
                        sel_d   = REQ_D;
                        state_d = ISSUE;
                    end
                end
                ISSUE: begin
                    mem_req = 1'b1;
                    if (sel_q == REQ_I) begin
                        mem_addr  = i_addr;
                        mem_we    = i_we;
                        mem_be    = i_be;
                        mem_wdata = i_wdata;
                    end else begin
                        mem_addr  = d_addr;
                        mem_we    = d_we;
                        mem_be    = d_be;
                        mem_wdata = d_wdata;
                    end
                    if (mem_gnt) begin
                        if (sel_q == REQ_I) begin
                            i_gnt = 1'b1;
                        end else begin
                            d_gnt = 1'b1;
                        end
                        last_sel_d = sel_q;
                        state_d    = WAIT_RESP;
                    end
                end
                WAIT_RESP: begin
                    if (mem_rvalid) begin
                        if (sel_q == REQ_I) begin
                            i_rvalid = 1'b1;
                            i_rdata  = mem_rdata;
                        end else begin
                            d_rvalid = 1'b1;
                            d_rdata  = mem_rdata;
                        end
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // A response with nothing outstanding (including one abandoned by a
    // reset) latches the error flag until the next reset.
    always_comb begin
        spurious_d = spurious_q | (mem_rvalid && (state_q != WAIT_RESP));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            sel_q      <= REQ_I;
            last_sel_q <= REQ_D;
            spurious_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            last_sel_q <= last_sel_d;
            spurious_q <= spurious_d;
        end
    end

    assign spurious_rvalid = spurious_q;
    assign contention_inc  = i_req && d_req && !(i_gnt && d_gnt);

    sat_counter #(.WIDTH(CNT_WIDTH)) u_i_grant_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (i_gnt),
        .count (i_grant_cnt)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_d_grant_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (d_gnt),
        .count (d_grant_cnt)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_contention_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (contention_inc),
        .count (contention_cnt)
    );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Directed bench for mem_port_arbiter. The memory side is driven by hand in
// each step. A second instance with 2-bit counters shares every input and
// is used only to observe counter saturation.
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst;
    logic        i_req, i_we, d_req, d_we;
    logic [31:0] i_addr, i_wdata, d_addr, d_wdata;
    logic [3:0]  i_be, d_be;
    logic        mem_gnt, mem_rvalid;
    logic [31:0] mem_rdata;

    logic        i_gnt, i_rvalid, d_gnt, d_rvalid;
    logic [31:0] i_rdata, d_rdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] i_grant_cnt, d_grant_cnt, contention_cnt;
    logic        spurious_rvalid;

    logic        s_i_gnt, s_i_rvalid, s_d_gnt, s_d_rvalid;
    logic [31:0] s_i_rdata, s_d_rdata;
    logic        s_mem_req, s_mem_we;
    logic [31:0] s_mem_addr, s_mem_wdata;
    logic [3:0]  s_mem_be;
    logic [1:0]  s_i_grant_cnt, s_d_grant_cnt, s_contention_cnt;
    logic        s_spurious_rvalid;

    int total = 0;
    int bad   = 0;

    mem_port_arbiter dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_we(i_we), .i_be(i_be), .i_wdata(i_wdata),
        .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_addr(d_addr), .d_we(d_we), .d_be(d_be), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_we(mem_we), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata),
        .i_grant_cnt(i_grant_cnt), .d_grant_cnt(d_grant_cnt),
        .contention_cnt(contention_cnt), .spurious_rvalid(spurious_rvalid)
    );

    mem_port_arbiter #(.CNT_WIDTH(2)) dut_sat (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_we(i_we), .i_be(i_be), .i_wdata(i_wdata),
        .i_gnt(s_i_gnt), .i_rvalid(s_i_rvalid), .i_rdata(s_i_rdata),
        .d_req(d_req), .d_addr(d_addr), .d_we(d_we), .d_be(d_be), .d_wdata(d_wdata),
        .d_gnt(s_d_gnt), .d_rvalid(s_d_rvalid), .d_rdata(s_d_rdata),
        .mem_req(s_mem_req), .mem_addr(s_mem_addr), .mem_we(s_mem_we), .mem_be(s_mem_be),
        .mem_wdata(s_mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata),
        .i_grant_cnt(s_i_grant_cnt), .d_grant_cnt(s_d_grant_cnt),
        .contention_cnt(s_contention_cnt), .spurious_rvalid(s_spurious_rvalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net: the directed sequence is a few hundred cycles long.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs,
                               input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are checked
    // after a further settle delay, well away from the next edge.
    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic applyStimulus(input logic ireq, input logic [31:0] iaddr,
                                 input logic dreq, input logic [31:0] daddr);
        i_req  = ireq;
        i_addr = iaddr;
        d_req  = dreq;
        d_addr = daddr;
    endtask

    task automatic doReset();
        rst        = 1'b1;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
        nextCycle();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        i_req = 0; i_we = 0; i_be = 4'hF; i_addr = 0; i_wdata = 0;
        d_req = 0; d_we = 0; d_be = 4'hF; d_addr = 0; d_wdata = 0;
        mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;

        // ---------------- reset values ----------------
        settle();
        checkOutput("rst_mem_req", mem_req, 0);
        checkOutput("rst_i_gnt", i_gnt, 0);
        checkOutput("rst_d_rvalid", d_rvalid, 0);
        nextCycle();
        settle();
        checkOutput("rst_i_cnt", i_grant_cnt, 0);
        checkOutput("rst_d_cnt", d_grant_cnt, 0);
        checkOutput("rst_cont_cnt", contention_cnt, 0);
        checkOutput("rst_spurious", spurious_rvalid, 0);
        nextCycle();
        rst = 1'b0;

        // ---------------- single instruction read ----------------
        applyStimulus(1'b1, 32'h0000_0040, 1'b0, 32'h0);
        settle();
        checkOutput("t1_idle_mem_req", mem_req, 0);
        checkOutput("t1_idle_i_gnt", i_gnt, 0);
        nextCycle();
        mem_gnt = 1'b1;
        settle();
        checkOutput("t1_mem_req", mem_req, 1);
        checkOutput("t1_mem_addr", mem_addr, 32'h40);
        checkOutput("t1_mem_we", mem_we, 0);
        checkOutput("t1_i_gnt", i_gnt, 1);
        checkOutput("t1_d_gnt", d_gnt, 0);
        nextCycle();
        mem_gnt = 1'b0;
        i_req = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata = 32'h10;
        settle();
        checkOutput("t1_wait_mem_req", mem_req, 0);
        checkOutput("t1_i_rvalid", i_rvalid, 1);
        checkOutput("t1_i_rdata", i_rdata, 32'h10);
        checkOutput("t1_d_rvalid", d_rvalid, 0);
        checkOutput("t1_d_rdata", d_rdata, 0);
        nextCycle();
        mem_rvalid = 1'b0;
        settle();
        checkOutput("t1_i_cnt", i_grant_cnt, 1);
        checkOutput("t1_d_cnt", d_grant_cnt, 0);
        checkOutput("t1_spurious", spurious_rvalid, 0);

        // ---------------- simultaneous requests after reset ----------------
        // The I side keeps its request up until its response, so both
        // requests are high for IDLE, ISSUE and WAIT_RESP of I: 3 cycles.
        doReset();
        applyStimulus(1'b1, 32'h0, 1'b1, 32'h0010_0000);
        nextCycle();
        mem_gnt = 1'b1;
        settle();
        checkOutput("t2_first_addr", mem_addr, 32'h0);
        checkOutput("t2_first_i_gnt", i_gnt, 1);
        checkOutput("t2_first_d_gnt", d_gnt, 0);
        nextCycle();
        mem_gnt = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata = 32'h1111_0000;
        settle();
        checkOutput("t2_first_i_rvalid", i_rvalid, 1);
        nextCycle();
        mem_rvalid = 1'b0;
        i_req = 1'b0;
        settle();
        checkOutput("t2_bubble_mem_req", mem_req, 0);
        nextCycle();
        mem_gnt = 1'b1;
        settle();
        checkOutput("t2_second_addr", mem_addr, 32'h0010_0000);
        checkOutput("t2_second_d_gnt", d_gnt, 1);
        checkOutput("t2_second_i_gnt", i_gnt, 0);
        nextCycle();
        mem_gnt = 1'b0;
        d_req = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata = 32'h2222_0000;
        settle();
        checkOutput("t2_second_d_rvalid", d_rvalid, 1);
        checkOutput("t2_second_d_rdata", d_rdata, 32'h2222_0000);
        checkOutput("t2_second_i_rdata", i_rdata, 0);
        nextCycle();
        mem_rvalid = 1'b0;
        settle();
        checkOutput("t2_cont_cnt", contention_cnt, 3);
        checkOutput("t2_i_cnt", i_grant_cnt, 1);
        checkOutput("t2_d_cnt", d_grant_cnt, 1);

        // ---------------- continuous contention, 8 transactions ----------------
        // Both requests stay high throughout: grants go I,D,I,D,... and every
        // one of the 24 cycles counts as contended.
        doReset();
        applyStimulus(1'b1, 32'h0000_1000, 1'b1, 32'h0000_2000);
        for (int t = 0; t < 8; t++) begin
            settle();
            checkOutput($sformatf("t3_idle%0d_mem_req", t), mem_req, 0);
            nextCycle();
            mem_gnt = 1'b1;
            settle();
            checkOutput($sformatf("t3_tx%0d_i_gnt", t), i_gnt, (t % 2 == 0) ? 1 : 0);
            checkOutput($sformatf("t3_tx%0d_d_gnt", t), d_gnt, (t % 2 == 0) ? 0 : 1);
            checkOutput($sformatf("t3_tx%0d_addr", t), mem_addr,
                        (t % 2 == 0) ? 32'h0000_1000 : 32'h0000_2000);
            nextCycle();
            mem_gnt = 1'b0;
            mem_rvalid = 1'b1;
            mem_rdata = 32'h100 + t;
            nextCycle();
            mem_rvalid = 1'b0;
        end
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
        settle();
        checkOutput("t3_i_cnt", i_grant_cnt, 4);
        checkOutput("t3_d_cnt", d_grant_cnt, 4);
        checkOutput("t3_cont_cnt", contention_cnt, 24);

        // ---------------- data write with slow grant ----------------
        d_req = 1'b1;
        d_addr = 32'h0000_0200;
        d_we = 1'b1;
        d_be = 4'b0011;
        d_wdata = 32'hDEAD_BEEF;
        nextCycle();
        for (int w = 0; w < 4; w++) begin
            mem_gnt = (w == 3);
            settle();
            checkOutput($sformatf("t4_c%0d_mem_req", w), mem_req, 1);
            checkOutput($sformatf("t4_c%0d_mem_addr", w), mem_addr, 32'h200);
            checkOutput($sformatf("t4_c%0d_mem_we", w), mem_we, 1);
            checkOutput($sformatf("t4_c%0d_mem_be", w), mem_be, 4'b0011);
            checkOutput($sformatf("t4_c%0d_mem_wdata", w), mem_wdata, 32'hDEAD_BEEF);
            checkOutput($sformatf("t4_c%0d_d_gnt", w), d_gnt, (w == 3) ? 1 : 0);
            nextCycle();
        end
        mem_gnt = 1'b0;
        d_req = 1'b0;
        d_we = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata = 32'h0;
        settle();
        checkOutput("t4_d_rvalid", d_rvalid, 1);
        checkOutput("t4_mem_req", mem_req, 0);
        nextCycle();
        mem_rvalid = 1'b0;
        settle();
        checkOutput("t4_d_cnt", d_grant_cnt, 5);
        checkOutput("t4_cont_cnt", contention_cnt, 24);

        // ---------------- reset during WAIT_RESP ----------------
        applyStimulus(1'b1, 32'h0000_0080, 1'b0, 32'h0);
        nextCycle();
        mem_gnt = 1'b1;
        settle();
        checkOutput("t5_i_gnt", i_gnt, 1);
        nextCycle();
        mem_gnt = 1'b0;
        i_req = 1'b0;
        rst = 1'b1;
        settle();
        checkOutput("t5_rst_mem_req", mem_req, 0);
        checkOutput("t5_rst_i_rvalid", i_rvalid, 0);
        nextCycle();
        rst = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata = 32'h55;
        settle();
        checkOutput("t5_late_i_rvalid", i_rvalid, 0);
        checkOutput("t5_late_d_rvalid", d_rvalid, 0);
        checkOutput("t5_late_i_rdata", i_rdata, 0);
        nextCycle();
        mem_rvalid = 1'b0;
        mem_gnt = 1'b1;
        settle();
        checkOutput("t5_spurious_set", spurious_rvalid, 1);
        checkOutput("t5_i_cnt", i_grant_cnt, 0);
        checkOutput("t5_d_cnt", d_grant_cnt, 0);
        checkOutput("t5_cont_cnt", contention_cnt, 0);
        checkOutput("t5_idle_gnt_i", i_gnt, 0);
        checkOutput("t5_idle_gnt_d", d_gnt, 0);
        nextCycle();
        mem_gnt = 1'b0;
        nextCycle();
        settle();
        checkOutput("t5_spurious_sticky", spurious_rvalid, 1);

        // ---------------- saturation with 2-bit counters ----------------
        doReset();
        settle();
        checkOutput("t6_spurious_cleared", spurious_rvalid, 0);
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b1, 32'h0000_3000 + 32'(k * 4), 1'b0, 32'h0);
            nextCycle();
            mem_gnt = 1'b1;
            settle();
            checkOutput($sformatf("t6_tx%0d_i_gnt", k), s_i_gnt, 1);
            nextCycle();
            mem_gnt = 1'b0;
            i_req = 1'b0;
            mem_rvalid = 1'b1;
            mem_rdata = 32'(k);
            nextCycle();
            mem_rvalid = 1'b0;
            settle();
            checkOutput($sformatf("t6_tx%0d_sat_cnt", k), s_i_grant_cnt, (k < 3) ? k + 1 : 3);
        end
        checkOutput("t6_wide_i_cnt", i_grant_cnt, 5);
        checkOutput("t6_sat_d_cnt", s_d_grant_cnt, 0);
        checkOutput("t6_sat_spurious", s_spurious_rvalid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one OBI-style memory request port between the instruction-side and data-side refill paths of the direct-mapped cache system, so both caches can sit behind a single AXI bridge / VIP slave. One transaction is in flight at a time. Contention resolves round-robin, and saturating performance counters feed the simulation statistics.

## Interface
Parameters:
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, data width; byte-enable width is DATA_WIDTH/8
- CNT_WIDTH, 32, width of each statistics counter

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- i_req, i_addr, i_we, i_be, i_wdata  in  1/ADDR_WIDTH/1/DATA_WIDTH/8/DATA_WIDTH  instruction-side request
- i_gnt  out  1  instruction request accepted
- i_rvalid, i_rdata  out  1/DATA_WIDTH  instruction response
- d_req, d_addr, d_we, d_be, d_wdata  in  same widths  data-side request
- d_gnt, d_rvalid, d_rdata  out  1/1/DATA_WIDTH  data-side grant and response
- mem_req, mem_addr, mem_we, mem_be, mem_wdata  out  as above  downstream request
- mem_gnt, mem_rvalid, mem_rdata  in  1/1/DATA_WIDTH  downstream grant and response
- i_grant_cnt, d_grant_cnt, contention_cnt  out  CNT_WIDTH each  statistics
- spurious_rvalid  out  1  sticky error flag

## Operation
- Requester rule: once raised, req and its addr/we/be/wdata are held stable until the matching gnt.
- FSM states: IDLE, ISSUE, WAIT_RESP.
- IDLE:
  - Only i_req: sel<=I, go to ISSUE.
  - Only d_req: sel<=D, go to ISSUE.
  - Both: sel<= the requester not in last_sel, go to ISSUE.
  - Neither: stay in IDLE.
- ISSUE:
  - mem_req=1; mem_addr/we/be/wdata are muxed from the requester named by sel.
  - On mem_gnt: the selected gnt=mem_gnt (combinational); last_sel<=sel; go to WAIT_RESP.
- WAIT_RESP:
  - mem_req=0.
  - On mem_rvalid: the selected rvalid=1 and rdata=mem_rdata (combinational); go to IDLE.
  - Writes also complete with an rvalid.
- The unselected requester's gnt and rvalid are always 0. Its rdata is a don't-care; the implementation drives it to 0.
- mem_rvalid in IDLE or ISSUE sets spurious_rvalid. The flag is cleared only by rst. The response is not forwarded.
- mem_gnt outside ISSUE is ignored.
- Counters saturate at all-ones and never wrap:
  - i_grant_cnt / d_grant_cnt: +1 on each i_gnt / d_gnt.
  - contention_cnt: +1 for every cycle in which i_req and d_req are both high and at least one of them is not granted that cycle.
- Reset mid-transaction:
  - FSM returns to IDLE; any outstanding response is abandoned.
  - A late mem_rvalid then sets spurious_rvalid. This is required and documented: the bench must reset memory alongside.

## Timing
- Reset values: state=IDLE, sel=I, last_sel=D (instruction side wins the first tie), all counters 0, spurious_rvalid 0.
- All outputs 0 during and immediately after reset.
- Latency:
  - Request visible in IDLE at cycle N gives mem_req at N+1.
  - gnt in the same cycle as mem_gnt.
  - rvalid in the same cycle as mem_rvalid.
  - Zero-wait memory (gnt at N+1, rvalid at N+2): one transaction per 3 cycles.
- The cycle after rvalid is always IDLE, so there is one bubble between back-to-back transactions.
- No combinational path from mem_gnt or mem_rvalid to mem_req.
- Fairness: with both sides continuously requesting, grants strictly alternate. Maximum wait is one transaction.

## Structure
- Package kuuga_arb_pkg:
  - typedef enum logic [1:0] arb_state_t {IDLE, ISSUE, WAIT_RESP}
  - typedef enum logic {REQ_I, REQ_D} req_id_t
- Sub-module sat_counter (parameter WIDTH; ports clk, rst, inc, count), instantiated three times.
- Everything else lives inline in mem_port_arbiter.

## Test plan
- Single instruction read: i_req with i_addr=0x0000_0040; memory gnt at N+1, rvalid at N+2 with rdata=0x10 → i_gnt at N+1, i_rvalid at N+2 carrying 0x10, i_grant_cnt=1, d_* outputs stay 0.
- Simultaneous requests after reset: i_addr=0x0, d_addr=0x0010_0000, both held → I served first, then D. mem_addr sequence 0x0, 0x0010_0000. contention_cnt=3 with zero-wait memory.
- Continuous contention for 8 transactions → grants alternate I,D,I,D…; i_grant_cnt=4, d_grant_cnt=4.
- Data write: d_we=1, d_be=4'b0011, d_wdata=0xDEAD_BEEF; memory delays gnt 3 cycles → mem_req held with stable fields for 4 cycles; d_gnt only in the mem_gnt cycle.
- Reset asserted in WAIT_RESP, then a late mem_rvalid → no rvalid forwarded, spurious_rvalid=1 and sticky, counters 0 after reset.
- Saturation with CNT_WIDTH=2: 5 instruction transactions → i_grant_cnt stops at 3.
